// File: rtl/sig_mul_seq.sv
// ============================================================================
// Module      : sig_mul_seq
// Description : Multi-cycle shift-and-add multiplier for NSIG+1-bit
//               significands. Optional early exit with SIG_MUL_EARLY_EXIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sig_mul_seq #(
    parameter int NSIG = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NSIG:0]       a_sig,
    input  logic [NSIG:0]       b_sig,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*NSIG+1:0]   product
);

    localparam int CW = $clog2(NSIG + 1);
    localparam int PW = 2 * NSIG + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [NSIG:0]   mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{(NSIG + 1){1'b0}}, a_sig};
                    mplier_d = b_sig;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef SIG_MUL_EARLY_EXIT_EN
                    state_d  = (b_sig == '0) ? S_DONE : S_RUN;
`else
                    state_d  = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
`ifdef SIG_MUL_EARLY_EXIT_EN
                // Remaining multiplier bits all zero: no further adds possible.
                if ((cnt_q == CW'(NSIG)) || ((mplier_q >> 1) == '0)) begin
                    state_d = S_DONE;
                end
`else
                if (cnt_q == CW'(NSIG)) begin
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign product   = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_sig_mul_seq.sv
// ============================================================================
// Module      : tb_sig_mul_seq
// Description : Self-checking bench for sig_mul_seq (vector table, random
//               sweep against a*b, and hand-written handshake/reset sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sig_mul_seq;

    localparam int NSIG = 10;
    localparam int SW   = NSIG + 1;
    localparam int PW   = 2 * NSIG + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] a_sig;
    logic [SW-1:0] b_sig;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;

    int vectors    = 0;
    int miscompares = 0;

    sig_mul_seq #(.NSIG(NSIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_sig     (a_sig),
        .b_sig     (b_sig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] a;
        logic [SW-1:0] b;
        logic [PW-1:0] p;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer product, and latency from the operand's bit length.
    function automatic logic [PW-1:0] ref_mul(input logic [SW-1:0] a, input logic [SW-1:0] b);
        longint unsigned r;
        r = longint'(a) * longint'(b);
        return r[PW-1:0];
    endfunction

    function automatic int ref_lat(input logic [SW-1:0] b);
`ifdef SIG_MUL_EARLY_EXIT_EN
        int msb;
        msb = -1;
        for (int i = 0; i < SW; i++) if (b[i]) msb = i;
        return msb + 1;
`else
        return NSIG + 1;
`endif
    endfunction

    // Called at a negedge. Returns the product and the number of edges from
    // the accept edge until out_valid is seen; completes the handshake.
    task automatic run_op(input logic [SW-1:0] a, input logic [SW-1:0] b,
                          output logic [PW-1:0] prod, output int lat,
                          input bit chk_pulse);
        int n;
        in_valid  = 1'b1;
        a_sig     = a;
        b_sig     = b;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a_sig    = SW'($urandom);
        b_sig    = SW'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            chk("done_timeout", 64'(out_valid), 64'd1);
            lat = -1;
        end
        prod = product;
        @(posedge clk);
        @(negedge clk);
        if (chk_pulse) begin
            chk("out_valid_pulse", 64'(out_valid), 64'd0);
            chk("in_ready_after_done", 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        vec_t          tbl[8];
        logic [PW-1:0] p, held;
        int            lat;
        logic [SW-1:0] ra, rb;
        logic [SW-1:0] qa[4], qb[4];
        logic [PW-1:0] expq[$];
        int            k, results, last_acc;
        bit            acc_now;

        tbl[0] = '{a: 11'h400, b: 11'h400, p: 22'h100000};
        tbl[1] = '{a: 11'h7FF, b: 11'h7FF, p: 22'h3FF001};
        tbl[2] = '{a: 11'h7FF, b: 11'h001, p: 22'h0007FF};
        tbl[3] = '{a: 11'h7FF, b: 11'h000, p: 22'h000000};
        tbl[4] = '{a: 11'h555, b: 11'h003, p: 22'h000FFF};
        tbl[5] = '{a: 11'h000, b: 11'h7FF, p: 22'h000000};
        tbl[6] = '{a: 11'h400, b: 11'h7FF, p: 22'h1FFC00};
        tbl[7] = '{a: 11'h001, b: 11'h001, p: 22'h000001};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_sig = '0; b_sig = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_product", 64'(product), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, p, lat, 1'b1);
            chk($sformatf("tbl%0d_product", i), 64'(p), 64'(tbl[i].p));
            chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(ref_lat(tbl[i].b)));
        end

        for (int i = 0; i < 2000; i++) begin
            ra = SW'($urandom);
            rb = SW'($urandom);
            run_op(ra, rb, p, lat, 1'b0);
            chk("rand_product", 64'(p), 64'(ref_mul(ra, rb)));
        end

        // Backpressure: DONE held while out_ready=0, in_valid pulses ignored.
        in_valid = 1'b1; a_sig = 11'h123; b_sig = 11'h456; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        held = product;
        chk("bp_product", 64'(held), 64'(ref_mul(11'h123, 11'h456)));
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a_sig = SW'($urandom);
            b_sig = SW'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_product_stable", 64'(product), 64'(held));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_no_ghost_accept", 64'(in_ready), 64'd1);

        // Reset five cycles into RUN abandons the operation.
        in_valid = 1'b1; a_sig = 11'h7FF; b_sig = 11'h7FF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_run_in_ready", 64'(in_ready), 64'd1);
        chk("rst_run_out_valid", 64'(out_valid), 64'd0);
        chk("rst_run_product", 64'(product), 64'd0);
        run_op(11'h555, 11'h003, p, lat, 1'b1);
        chk("post_rst_product", 64'(p), 64'h0FFF);

        // Reset in DONE wins over a simultaneous handshake.
        in_valid = 1'b1; a_sig = 11'h3AB; b_sig = 11'h7C1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (NSIG + 1) @(posedge clk);
        @(negedge clk);
        chk("rst_done_reached", 64'(out_valid), 64'd1);
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_done_out_valid", 64'(out_valid), 64'd0);
        chk("rst_done_product", 64'(product), 64'd0);

        // Back-to-back: in_valid and out_ready held high.
        for (int i = 0; i < 4; i++) begin
            qa[i] = SW'($urandom) | 11'h400;
            qb[i] = SW'($urandom) | 11'h400;
        end
        k = 0; results = 0; last_acc = 0;
        in_valid = 1'b1; a_sig = qa[0]; b_sig = qb[0]; out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && results < 4; cyc++) begin
            if (out_valid) begin
                if (expq.size() > 0) chk("b2b_product", 64'(product), 64'(expq.pop_front()));
                else chk("b2b_unexpected_result", 64'(out_valid), 64'd0);
                results++;
            end
            acc_now = in_ready && (k < 4);
            if (acc_now) begin
                expq.push_back(ref_mul(qa[k], qb[k]));
                if (k > 0) chk("b2b_spacing", 64'(cyc - last_acc), 64'(NSIG + 3));
                last_acc = cyc;
            end
            @(posedge clk);
            @(negedge clk);
            if (acc_now) begin
                k++;
                if (k < 4) begin
                    a_sig = qa[k];
                    b_sig = qb[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("b2b_result_count", 64'(results), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
